// File: rtl/rx_lane_deskew.sv
// rx_lane_deskew: per-lane symbol FIFOs aligned on a common COM and released in lockstep.
// Optional build macro DESKEW_STATS_EN adds the maxSkew statistics output.
module rx_lane_deskew #(
    parameter int         LANESNUMBER = 16,
    parameter int         DEPTH       = 8,
    parameter logic [7:0] COM_SYMBOL  = 8'hBC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [8*LANESNUMBER-1:0]   RxData,
    input  logic [LANESNUMBER-1:0]     RxDataK,
    input  logic [LANESNUMBER-1:0]     RxDataValid,
    input  logic [LANESNUMBER-1:0]     activeLanes,
    input  logic                       deskewEnable,
    output logic [8*LANESNUMBER-1:0]   DeskewData,
    output logic [LANESNUMBER-1:0]     DeskewDataK,
    output logic [LANESNUMBER-1:0]     DeskewValid,
    output logic                       deskewLocked,
    output logic                       deskewError
`ifdef DESKEW_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]     maxSkew
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTRONE    = (AW+1)'(1);
    localparam logic [AW:0] FULLCOUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ALIGN, LOCKED} stateT;
    stateT state;

    logic [LANESNUMBER-1:0]   activeReg;
    logic [LANESNUMBER-1:0]   fifoEmpty, fifoFull, headIsCom, push, pop, overflowLane;
    logic [LANESNUMBER-1:0]   headK;
    logic [8*LANESNUMBER-1:0] headData, byteMask;
    logic [LANESNUMBER-1:0]   activeHeadsCom;
    logic anyActive, allParked, allReady, misalign, overflow, laneChange, flush;

    genvar gi;
    generate
        for (gi = 0; gi < LANESNUMBER; gi++) begin : gLane
            logic [8:0]  mem [DEPTH];
            logic [AW:0] wrPtr, rdPtr, count;
            logic        wrEn;

            assign count              = wrPtr - rdPtr;
            assign fifoEmpty[gi]      = (count == '0);
            assign fifoFull[gi]       = (count == FULLCOUNT);
            assign headK[gi]          = mem[rdPtr[AW-1:0]][8];
            assign headData[8*gi +: 8] = mem[rdPtr[AW-1:0]][7:0];
            assign byteMask[8*gi +: 8] = {8{activeLanes[gi]}};
            assign headIsCom[gi]      = !fifoEmpty[gi] && headK[gi] &&
                                        (headData[8*gi +: 8] == COM_SYMBOL);
            assign push[gi]           = RxDataValid[gi] && activeLanes[gi] && (state != IDLE);
            // A full FIFO still accepts a write when its head leaves in the same cycle.
            assign wrEn               = push[gi] && (!fifoFull[gi] || pop[gi]);
            assign overflowLane[gi]   = push[gi] && fifoFull[gi] && !pop[gi];

            always_ff @(posedge clk) begin
                if (wrEn) begin
                    mem[wrPtr[AW-1:0]] <= {RxDataK[gi], RxData[8*gi +: 8]};
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wrPtr <= '0;
                    rdPtr <= '0;
                end else if (flush) begin
                    wrPtr <= '0;
                    rdPtr <= '0;
                end else begin
                    if (wrEn)    wrPtr <= wrPtr + PTRONE;
                    if (pop[gi]) rdPtr <= rdPtr + PTRONE;
                end
            end
        end
    endgenerate

    assign activeHeadsCom = headIsCom & activeLanes;
    assign anyActive      = |activeLanes;
    assign allParked      = anyActive && (activeHeadsCom == activeLanes);
    assign allReady       = anyActive && ((~fifoEmpty & activeLanes) == activeLanes);
    assign misalign       = (activeHeadsCom != '0) && (activeHeadsCom != activeLanes);
    assign overflow       = |(overflowLane & activeLanes);
    assign laneChange     = (activeLanes != activeReg);

    always_comb begin
        pop = '0;
        if (state == ALIGN) begin
            pop = activeLanes & ~fifoEmpty & ~headIsCom;
        end else if (state == LOCKED && allReady) begin
            pop = activeLanes;
        end
    end

    always_comb begin
        flush = 1'b0;
        if (!deskewEnable || state == IDLE) begin
            flush = 1'b1;
        end else if (laneChange || overflow) begin
            flush = 1'b1;
        end else if (state == LOCKED && allReady && misalign) begin
            flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            activeReg    <= '0;
            DeskewData   <= '0;
            DeskewDataK  <= '0;
            DeskewValid  <= '0;
            deskewLocked <= 1'b0;
            deskewError  <= 1'b0;
        end else begin
            activeReg    <= activeLanes;
            DeskewData   <= '0;
            DeskewDataK  <= '0;
            DeskewValid  <= '0;
            deskewLocked <= 1'b0;
            deskewError  <= 1'b0;
            if (!deskewEnable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (anyActive) state <= ALIGN;
                    end
                    ALIGN: begin
                        if (laneChange) begin
                            state <= ALIGN;
                        end else if (overflow) begin
                            deskewError <= 1'b1;
                        end else if (allParked) begin
                            state        <= LOCKED;
                            deskewLocked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (laneChange) begin
                            state <= ALIGN;
                        end else if (overflow || (allReady && misalign)) begin
                            // The popped symbols are discarded; the lanes realign on the next COM.
                            state       <= ALIGN;
                            deskewError <= 1'b1;
                        end else begin
                            deskewLocked <= 1'b1;
                            if (allReady) begin
                                DeskewValid <= activeLanes;
                                DeskewData  <= headData & byteMask;
                                DeskewDataK <= headK & activeLanes;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef DESKEW_STATS_EN
    logic [AW:0] skewCount;

    // Counts the cycles between the first and the last active lane parking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skewCount <= '0;
            maxSkew   <= '0;
        end else if (!deskewEnable || state == IDLE) begin
            skewCount <= '0;
            maxSkew   <= '0;
        end else if (state == ALIGN && !flush) begin
            if (allParked) begin
                if (skewCount > maxSkew) maxSkew <= skewCount;
                skewCount <= '0;
            end else if (activeHeadsCom != '0 && skewCount != '1) begin
                skewCount <= skewCount + PTRONE;
            end
        end else begin
            skewCount <= '0;
        end
    end
`endif

endmodule

// File: doc/rx_lane_deskew.md
Name: rx_lane_deskew

Overview:
- Per-lane skew-removal stage on the Gen1/Gen2 8b/10b receive path, placed between the PIPE Rx interface (RxData/RxDataK/RxDataValid) and the RX ordered-set/packet logic.
- Buffers each lane in a small FIFO and aligns all active lanes on a common COM symbol (K28.5, 0xBC with K=1).
- Releases the lanes in lockstep so the RX block sees the same ordered-set symbol on every active lane in the same cycle.

Parameters:
- LANESNUMBER, 16, number of physical lanes.
- DEPTH, 8, per-lane FIFO entries; the maximum correctable skew is DEPTH-1 symbol times. Must be a power of 2, minimum 4.
- COM_SYMBOL, 8'hBC, alignment symbol; matched only when the K bit is set.

Ports:
- clk  input  1  PIPE clock.
- reset  input  1  asynchronous, active-high reset.
- RxData  input  8*LANESNUMBER  per-lane symbol; lane i occupies bits [8i+7:8i].
- RxDataK  input  LANESNUMBER  per-lane K flag.
- RxDataValid  input  LANESNUMBER  per-lane symbol strobe.
- activeLanes  input  LANESNUMBER  lanes taking part in alignment; driven from numberOfDetectedLanes by the LTSSM.
- deskewEnable  input  1  0 = flush and stay in IDLE.
- DeskewData  output  8*LANESNUMBER  aligned symbols.
- DeskewDataK  output  LANESNUMBER  aligned K flags.
- DeskewValid  output  LANESNUMBER  aligned strobe; either all active lanes or zero.
- deskewLocked  output  1  lanes are aligned.
- deskewError  output  1  one-cycle pulse on overflow or lost alignment.

Behaviour:
- Reset values: all outputs 0; FIFOs empty; FSM in IDLE.
- Write side, per lane:
  - Push {K, data} when RxDataValid[i]=1 and activeLanes[i]=1.
  - Inactive lanes never push and their outputs stay 0.
  - Pointers are log2(DEPTH) bits wide plus one wrap bit. full = (count == DEPTH). empty = (count == 0).
  - A push to a full FIFO is an overflow.
- FSM states:
  - IDLE: entered after reset and whenever deskewEnable=0 (from any state, next cycle). All FIFOs are flushed and deskewLocked=0. Go to ALIGN when deskewEnable=1 and activeLanes != 0.
  - ALIGN:
    - Per lane, pop and discard the head while the head is not COM.
    - A lane whose head is COM stops popping ("parked").
    - When every active lane is parked in the same cycle, go to LOCKED. Nothing is popped that cycle.
    - Overflow on any active lane: pulse deskewError, flush all FIFOs, stay in ALIGN.
  - LOCKED:
    - deskewLocked=1.
    - Each cycle where every active lane is non-empty: pop one entry from each active lane. The next cycle, drive DeskewData/DeskewDataK with the popped entries and DeskewValid=activeLanes (1-cycle registered latency).
    - If any active lane is empty: no pop on any lane, and DeskewValid=0 the next cycle.
    - Misalignment: at a lockstep pop, the set of active lanes with COM at the head is neither empty nor all active lanes. Then pulse deskewError, deskewLocked=0, flush, go to ALIGN. The popped data is not presented (DeskewValid stays 0).
    - Overflow in LOCKED: same handling as misalignment.
    - A change of activeLanes while in LOCKED or ALIGN: flush and go to ALIGN, with no error pulse.
- Simultaneous events:
  - A push and a pop on the same lane in the same cycle are both performed; count is unchanged.
  - A push on a full FIFO with a simultaneous pop is not an overflow.
  - deskewEnable=0 has priority over error handling.
- Reset asserted mid-operation: immediate return to the reset state, with no error pulse.
- Latency: zero-skew input appears on the DeskewData outputs 2 cycles after its push (1 cycle FIFO write plus 1 cycle output register) once LOCKED.

Optional Feature:
- Macro DESKEW_STATS_EN.
- When defined:
  - Adds output maxSkew, width log2(DEPTH)+1 bits.
  - In ALIGN, a counter starts at the first lane parking and stops when the last active lane parks. On entry to LOCKED, maxSkew is updated with max(maxSkew, count).
  - maxSkew is cleared by reset or by IDLE.
- When not defined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
1. Zero skew, activeLanes=16'h000F, all 4 lanes send BC/K then 4A,4A,... every cycle -> deskewLocked=1. DeskewData lanes 0-3 show BC with DeskewDataK=4'hF on the same cycle, then 4A on the next cycle. DeskewValid=16'h000F.
2. Lane 2 delayed 3 symbols relative to lanes 0,1,3 -> lock achieved; every subsequent output cycle shows identical symbols on lanes 0-3. With DESKEW_STATS_EN, maxSkew=3.
3. Lane 1 delayed 8 symbols with DEPTH=8 -> overflow; deskewError pulses 1 cycle; deskewLocked stays 0; lock is reacquired after the skew drops to 2.
4. While LOCKED, insert one extra symbol on lane 3 only -> the next COM is at the head on lanes 0-2 but not lane 3; deskewError pulses; deskewLocked=0; realignment completes on the following COM.
5. While LOCKED, lane 0 RxDataValid=0 for 2 cycles -> DeskewValid=0 for 2 cycles with no data lost; the sequence resumes in order with no error.
6. Assert reset during ALIGN with partial FIFOs, and separately drop deskewEnable in LOCKED -> all outputs 0 and FIFOs empty (reset case: immediately; deskewEnable case: next cycle); no deskewError pulse in either case.
